// File: rtl/huffman_dec_arbiter_if.sv
// Request / decoder-core / response bundle for huffman_dec_arbiter.
// master: arbiter side (accepts requests, drives the core bit stream and responses).
// slave : environment side (requesters, decoder core, response consumer).
interface huffman_dec_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int CODE_W = 5,
  parameter int SYM_W  = 5
);
  localparam int ID_W = $clog2(NREQ);

  // requester side
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*CODE_W-1:0] req_code;
  logic [NREQ-1:0]        req_ready;
  // decoder core side
  logic                   dec_start;
  logic                   dec_bit;
  logic [SYM_W-1:0]       dec_sym;
  logic                   dec_sym_valid;
  // response channel
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [SYM_W-1:0]       rsp_symbol;
  logic                   rsp_error;
  // status
  logic                   busy;

  modport master (
    input  req_valid, req_code, dec_sym, dec_sym_valid, rsp_ready,
    output req_ready, dec_start, dec_bit, rsp_valid, rsp_id, rsp_symbol, rsp_error, busy
  );

  modport slave (
    output req_valid, req_code, dec_sym, dec_sym_valid, rsp_ready,
    input  req_ready, dec_start, dec_bit, rsp_valid, rsp_id, rsp_symbol, rsp_error, busy
  );
endinterface

// File: rtl/huffman_dec_arbiter.sv
// Purpose : round-robin share of one huffman decoder core among NREQ requesters;
//           the granted codeword is serialised MSB-first, the symbol (or a timeout
//           error) comes back as {id, symbol, error} on one response channel.
// Latency : accept on cycle 0, bits on cycles 1..CODE_W, response no earlier than CODE_W+2.
// Backpressure: one codeword in flight; req_ready stays 0 until the response handshakes,
//           response fields hold while rsp_ready is low.
// Ports   : clk, reset (async, active-high), bus (master modport of huffman_dec_arbiter_if).
module huffman_dec_arbiter #(
  parameter int NREQ    = 4,
  parameter int CODE_W  = 5,
  parameter int SYM_W   = 5,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  huffman_dec_arbiter_if.master bus
);
  localparam int ID_W = $clog2(NREQ);
  localparam int BC_W = $clog2(CODE_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]        to_cnt_q, to_cnt_d;
  logic              dec_start_q, dec_start_d;
  logic              dec_bit_q, dec_bit_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [SYM_W-1:0]  rsp_symbol_q, rsp_symbol_d;
  logic              rsp_error_q, rsp_error_d;

  // ---------------- round-robin arbitration ----------------
  // Rotating the doubled request vector by rr_ptr puts requester rr_ptr at bit 0,
  // so the lowest set bit of the rotated vector is the winner.
  logic [2*NREQ-1:0] req_rot;
  logic [ID_W:0]     cand;
  logic              grant_vld;
  logic [ID_W-1:0]   grant_id;
  logic [CODE_W-1:0] grant_code;

  always_comb begin
    req_rot   = {bus.req_valid, bus.req_valid} >> rr_ptr_q;
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    // Walk from the far end so the nearest requester is the last (winning) write.
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NREQ)) cand = cand - (ID_W+1)'(NREQ);
      if (req_rot[k]) begin
        grant_vld = 1'b1;
        grant_id  = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    grant_code = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == ID_W'(i)) grant_code = bus.req_code[i*CODE_W +: CODE_W];
    end
  end

  // The winner is granted only when it is valid, so req_ready[g] alone marks the transfer.
  assign bus.req_ready = (state_q == IDLE && grant_vld) ? (NREQ'(1) << grant_id) : '0;

  // ---------------- FSM next state / outputs ----------------
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    code_d       = code_q;
    bit_cnt_d    = bit_cnt_q;
    to_cnt_d     = to_cnt_q;
    dec_start_d  = 1'b0;
    dec_bit_d    = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_symbol_d = rsp_symbol_q;
    rsp_error_d  = rsp_error_q;

    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          // First bit goes out registered on the next cycle; code_q keeps the
          // remaining bits left-aligned so the next bit is always its MSB.
          id_d        = grant_id;
          code_d      = grant_code << 1;
          bit_cnt_d   = '0;
          dec_start_d = 1'b1;
          dec_bit_d   = grant_code[CODE_W-1];
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt_q == BC_W'(CODE_W - 1)) begin
          to_cnt_d = '0;
          state_d  = WAIT;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          dec_bit_d = code_q[CODE_W-1];
          code_d    = code_q << 1;
        end
      end
      WAIT: begin
        // A symbol arriving on the final timeout cycle still wins.
        if (bus.dec_sym_valid) begin
          rsp_valid_d  = 1'b1;
          rsp_id_d     = id_q;
          rsp_symbol_d = bus.dec_sym;
          rsp_error_d  = 1'b0;
          state_d      = RESP;
        end else if (to_cnt_q == 8'(TIMEOUT - 1)) begin
          rsp_valid_d  = 1'b1;
          rsp_id_d     = id_q;
          rsp_symbol_d = '0;
          rsp_error_d  = 1'b1;
          state_d      = RESP;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      code_q       <= '0;
      bit_cnt_q    <= '0;
      to_cnt_q     <= '0;
      dec_start_q  <= 1'b0;
      dec_bit_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_symbol_q <= '0;
      rsp_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      code_q       <= code_d;
      bit_cnt_q    <= bit_cnt_d;
      to_cnt_q     <= to_cnt_d;
      dec_start_q  <= dec_start_d;
      dec_bit_q    <= dec_bit_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_symbol_q <= rsp_symbol_d;
      rsp_error_q  <= rsp_error_d;
    end
  end

  assign bus.dec_start  = dec_start_q;
  assign bus.dec_bit    = dec_bit_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_symbol = rsp_symbol_q;
  assign bus.rsp_error  = rsp_error_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_huffman_dec_arbiter.sv
// Bench for huffman_dec_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all compared each cycle against a time-based
// transaction model (cycles elapsed since acceptance).
module tb_huffman_dec_arbiter;
  localparam int NREQ    = 4;
  localparam int CODE_W  = 5;
  localparam int SYM_W   = 5;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  huffman_dec_arbiter_if #(.NREQ(NREQ), .CODE_W(CODE_W), .SYM_W(SYM_W)) bus ();

  huffman_dec_arbiter #(.NREQ(NREQ), .CODE_W(CODE_W), .SYM_W(SYM_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // first valid requester at or after rr, wrapping; -1 if none
  function automatic int pick(input logic [NREQ-1:0] v, input int rr);
    for (int k = 0; k < NREQ; k++) if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
    return -1;
  endfunction

  // ---------------- reference model ----------------
  // In flight: m_t = cycle index since acceptance (1..CODE_W are bit cycles,
  // CODE_W+1..CODE_W+TIMEOUT are the wait window). m_done = response pending.
  bit               m_inflight, m_done;
  int               m_t, m_id, m_rr, m_rsp_id, mg, cg;
  logic [CODE_W-1:0] m_code;
  logic [SYM_W-1:0] m_sym;
  logic             m_err;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_inflight = 0; m_done = 0; m_t = 0; m_id = 0; m_rr = 0;
      m_rsp_id = 0; m_sym = '0; m_err = 1'b0; m_code = '0;
    end else if (!m_inflight) begin
      mg = pick(bus.req_valid, m_rr);
      if (mg >= 0) begin
        m_inflight = 1; m_done = 0; m_t = 1; m_id = mg;
        m_code = bus.req_code[mg*CODE_W +: CODE_W];
      end
    end else if (!m_done) begin
      if (m_t > CODE_W && (bus.dec_sym_valid || m_t == CODE_W + TIMEOUT)) begin
        m_done   = 1;
        m_rsp_id = m_id;
        m_err    = !bus.dec_sym_valid;
        m_sym    = bus.dec_sym_valid ? bus.dec_sym : '0;
      end
      m_t++;
    end else if (bus.rsp_ready) begin
      m_inflight = 0;
      m_rr = (m_id + 1) % NREQ;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      cg = pick(bus.req_valid, m_rr);
      chk("m_req_ready", bus.req_ready, (!m_inflight && cg >= 0) ? (32'(1) << cg) : 32'(0));
      chk("m_busy", bus.busy, m_inflight);
      chk("m_dec_start", bus.dec_start, m_inflight && !m_done && m_t == 1);
      chk("m_dec_bit", bus.dec_bit,
          (m_inflight && !m_done && m_t >= 1 && m_t <= CODE_W) ? m_code[CODE_W - m_t] : 1'b0);
      chk("m_rsp_valid", bus.rsp_valid, m_inflight && m_done);
      chk("m_rsp_id", bus.rsp_id, m_rsp_id);
      chk("m_rsp_symbol", bus.rsp_symbol, m_sym);
      chk("m_rsp_error", bus.rsp_error, m_err);
    end
  end

  // ---------------- directed helpers ----------------
  logic [CODE_W-1:0] codes [NREQ];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: grant check, serial bits, symbol after sym_dly wait
  // cycles (-1 = never), response held for `hold` cycles with stray symbol pulses.
  task automatic xact(input logic [NREQ-1:0] vld, input int exp_g, input int sym_dly,
                      input int hold, input logic [SYM_W-1:0] sym, output int rsp_cyc);
    int  c;
    bit  exp_err;
    bus.req_valid = vld;
    #1;
    chk("grant", bus.req_ready, 32'(1) << exp_g);
    tick();
    c = 1;
    for (int k = 0; k < CODE_W; k++) begin
      #1;
      chk("dec_start", bus.dec_start, k == 0);
      chk("dec_bit", bus.dec_bit, codes[exp_g][CODE_W-1-k]);
      tick();
      c++;
    end
    while (!bus.rsp_valid && c < 60) begin
      bus.dec_sym_valid = (c == CODE_W + 1 + sym_dly);
      bus.dec_sym = sym;
      tick();
      c++;
    end
    bus.dec_sym_valid = 1'b0;
    rsp_cyc = c;
    exp_err = !(sym_dly >= 0 && sym_dly < TIMEOUT);
    chk("rsp_valid", bus.rsp_valid, 1);
    chk("rsp_latency", c, exp_err ? CODE_W + 1 + TIMEOUT : CODE_W + 2 + sym_dly);
    chk("rsp_id", bus.rsp_id, exp_g);
    chk("rsp_error", bus.rsp_error, exp_err);
    chk("rsp_symbol", bus.rsp_symbol, exp_err ? '0 : sym);
    for (int h = 0; h < hold; h++) begin
      bus.dec_sym_valid = 1'b1;
      bus.dec_sym = ~sym;
      #1;
      chk("hold_rsp_valid", bus.rsp_valid, 1);
      chk("hold_rsp_id", bus.rsp_id, exp_g);
      chk("hold_rsp_symbol", bus.rsp_symbol, exp_err ? '0 : sym);
      chk("hold_req_ready", bus.req_ready, 0);
      chk("hold_busy", bus.busy, 1);
      tick();
    end
    bus.dec_sym_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("post_rsp_valid", bus.rsp_valid, 0);
    chk("post_busy", bus.busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rc;
    codes[0] = 5'b01101; codes[1] = 5'b10110; codes[2] = 5'b11100; codes[3] = 5'b00011;
    bus.req_valid = '0;
    for (int i = 0; i < NREQ; i++) bus.req_code[i*CODE_W +: CODE_W] = codes[i];
    bus.dec_sym = '0;
    bus.dec_sym_valid = 1'b0;
    bus.rsp_ready = 1'b0;

    // reset state
    tick(); tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_dec_start", bus.dec_start, 0);
    chk("rst_dec_bit", bus.dec_bit, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    rst = 1'b0;
    tick();

    // single req1, symbol one cycle after the last bit -> response on cycle 7
    xact(4'b0010, 1, 0, 0, 5'h0B, rc);
    chk("t1_rsp_cycle", rc, 7);

    // timeout, and a symbol on the very last wait cycle
    xact(4'b0001, 0, -1, 0, 5'h05, rc);
    chk("t3_timeout_cycle", rc, CODE_W + 1 + TIMEOUT);
    xact(4'b0001, 0, TIMEOUT - 1, 0, 5'h06, rc);
    chk("t3_lastwait_cycle", rc, 21);

    // response stalled 10 cycles (stray symbol pulses in RESP), then req0 re-accepted
    xact(4'b0001, 0, 2, 10, 5'h11, rc);
    xact(4'b0001, 0, 0, 0, 5'h12, rc);

    // reset during the third serial bit
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = '0;
    tick(); tick();
    #1;
    chk("t5_bit3_start", bus.dec_start, 0);
    rst = 1'b1;
    #1;
    chk("t5_busy", bus.busy, 0);
    chk("t5_dec_bit", bus.dec_bit, 0);
    chk("t5_rsp_valid", bus.rsp_valid, 0);
    chk("t5_rsp_symbol", bus.rsp_symbol, 0);
    chk("t5_rsp_id", bus.rsp_id, 0);
    chk("t5_req_ready", bus.req_ready, 0);
    tick(); tick();
    rst = 1'b0;
    // stray symbol pulses in IDLE
    for (int i = 0; i < 6; i++) begin
      bus.dec_sym_valid = 1'b1;
      bus.dec_sym = SYM_W'($urandom);
      tick();
      chk("t6_idle_busy", bus.busy, 0);
      chk("t6_idle_symbol", bus.rsp_symbol, 0);
      chk("t6_idle_rsp_valid", bus.rsp_valid, 0);
    end
    bus.dec_sym_valid = 1'b0;

    // round robin from requester 0 after reset
    for (int g = 0; g < NREQ; g++) xact(4'b1111, g, 1, 0, SYM_W'(5'h10 + g), rc);
    xact(4'b1100, 2, 0, 0, 5'h1A, rc);
    bus.req_valid = '0;
    tick();

    // randomized traffic, checked by the model every cycle
    for (int n = 0; n < 4000; n++) begin
      bus.req_valid = NREQ'($urandom);
      if ($urandom_range(0, 3) == 0) bus.req_code = (NREQ*CODE_W)'($urandom);
      bus.dec_sym_valid = ($urandom_range(0, 6) == 0);
      bus.dec_sym = SYM_W'($urandom);
      bus.rsp_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    bus.req_valid = '0;
    bus.dec_sym_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int n = 0; n < 40; n++) tick();
    chk("drain_busy", bus.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
